// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - game-side signal bundle between the play controller and score_keeper
interface score_keeper_if;
    logic [2:0] state;
    logic       note_arrive;
    logic [1:0] note_lane;
    logic [1:0] dir;
    logic [3:0] score;
    logic [3:0] miss;
    logic [3:0] combo;
    logic       judge_valid;
    logic       judge_hit;

    modport master (
        output state, note_arrive, note_lane, dir,
        input  score, miss, combo, judge_valid, judge_hit
    );

    modport slave (
        input  state, note_arrive, note_lane, dir,
        output score, miss, combo, judge_valid, judge_hit
    );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - judges note catches in a timing window and keeps per-round hit/miss/combo counts
module score_keeper #(
    parameter int WINDOW    = 25_000_000,
    parameter int ROUND_LEN = 10
) (
    input  logic         clk,
    input  logic         rst,
    score_keeper_if.slave sk
);
    localparam int CNT_W = $clog2(WINDOW) + 1;

    typedef enum logic [2:0] {IDLE, WAIT_NOTE, JUDGE, RESULT, DONE} fsm_t;

    fsm_t             cur, nxt;
    logic             note_q;
    logic [1:0]       lane_q;
    logic [CNT_W-1:0] win_cnt;
    logic             hit_flag;
    logic             hit_res;
    logic             hit_q;
    logic [3:0]       score_q, miss_q, combo_q;

    logic playing, note_event, hit_now, win_end, round_full;
    logic clear_counts, start_judge, end_judge, commit;

    assign playing    = (sk.state == 3'b010);
    assign note_event = sk.note_arrive & ~note_q;
    assign hit_now    = hit_flag | (sk.dir == lane_q);
    assign win_end    = (win_cnt == CNT_W'(WINDOW - 1));
    // Round completion is judged on the totals as they will be after this commit.
    assign round_full = (({1'b0, score_q} + {1'b0, miss_q} + 5'd1) == 5'(ROUND_LEN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= IDLE;
        else      cur <= nxt;
    end

    always_comb begin
        nxt          = cur;
        clear_counts = 1'b0;
        start_judge  = 1'b0;
        end_judge    = 1'b0;
        commit       = 1'b0;
        case (cur)
            IDLE: begin
                if (playing) begin
                    clear_counts = 1'b1;
                    nxt          = WAIT_NOTE;
                end
            end
            WAIT_NOTE: begin
                if (!playing) nxt = IDLE;
                else if (note_event) begin
                    start_judge = 1'b1;
                    nxt         = JUDGE;
                end
            end
            JUDGE: begin
                if (!playing) nxt = IDLE;
                else if (hit_now || win_end) begin
                    end_judge = 1'b1;
                    nxt       = RESULT;
                end
            end
            RESULT: begin
                if (!playing) nxt = IDLE;
                else begin
                    commit = 1'b1;
                    nxt    = round_full ? DONE : WAIT_NOTE;
                end
            end
            DONE: begin
                if (!playing) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            note_q   <= 1'b0;
            lane_q   <= 2'd0;
            win_cnt  <= '0;
            hit_flag <= 1'b0;
            hit_res  <= 1'b0;
            hit_q    <= 1'b0;
            score_q  <= 4'd0;
            miss_q   <= 4'd0;
            combo_q  <= 4'd0;
        end else begin
            note_q <= sk.note_arrive;
            if (start_judge) begin
                lane_q   <= sk.note_lane;
                win_cnt  <= '0;
                hit_flag <= 1'b0;
            end else if (cur == JUDGE) begin
                win_cnt <= win_cnt + CNT_W'(1);
                if (sk.dir == lane_q) hit_flag <= 1'b1;
            end
            if (end_judge) hit_res <= hit_now;
            if (clear_counts) begin
                score_q <= 4'd0;
                miss_q  <= 4'd0;
                combo_q <= 4'd0;
            end else if (commit) begin
                hit_q <= hit_res;
                if (hit_res) begin
                    score_q <= score_q + 4'd1;
                    if (combo_q != 4'hF) combo_q <= combo_q + 4'd1;
                end else begin
                    miss_q  <= miss_q + 4'd1;
                    combo_q <= 4'd0;
                end
            end
        end
    end

    // judge_hit shows the fresh result during the pulse, then the committed one.
    assign sk.judge_valid = commit;
    assign sk.judge_hit   = commit ? hit_res : hit_q;
    assign sk.score       = score_q;
    assign sk.miss        = miss_q;
    assign sk.combo       = combo_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper (WINDOW=8, ROUND_LEN=10)
module tb_score_keeper;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   pulse_cnt = 0;

    score_keeper_if sk();

    score_keeper #(.WINDOW(8), .ROUND_LEN(10)) dut (
        .clk (clk),
        .rst (rst),
        .sk  (sk)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sk.judge_valid === 1'b1) pulse_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_round();
        sk.state = 3'b000;
        tick();
        sk.state = 3'b010;
        tick();
        tick();
    endtask

    // Raises note_arrive and waits for the judge; lat = -1 when no pulse arrives.
    task automatic send_note(input logic [1:0] lane, output int lat, output logic hit);
        lat = -1;
        hit = 1'bx;
        sk.note_lane   = lane;
        sk.note_arrive = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (sk.judge_valid === 1'b1) begin
                lat = i;
                hit = sk.judge_hit;
                break;
            end
        end
        tick();
        sk.note_arrive = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sk.state = 3'b000; sk.note_arrive = 1'b0; sk.note_lane = 2'd0; sk.dir = 2'd0;
        tick(); tick();
        checks++; if (sk.score !== 4'd0) begin errors++; $display("FAIL reset_score got=%0d want=0", sk.score); end
        checks++; if (sk.miss !== 4'd0) begin errors++; $display("FAIL reset_miss got=%0d want=0", sk.miss); end
        checks++; if (sk.combo !== 4'd0) begin errors++; $display("FAIL reset_combo got=%0d want=0", sk.combo); end
        checks++; if (sk.judge_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", sk.judge_valid); end
        checks++; if (sk.judge_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b want=0", sk.judge_hit); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        int lat; logic hit;
        new_round();
        sk.dir = 2'd2;
        send_note(2'd2, lat, hit);
        checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency got=%0d want=2", lat); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_result got=%b want=1", hit); end
        checks++; if (sk.score !== 4'd1) begin errors++; $display("FAIL hit_score got=%0d want=1", sk.score); end
        checks++; if (sk.combo !== 4'd1) begin errors++; $display("FAIL hit_combo got=%0d want=1", sk.combo); end
    endtask

    task automatic test_miss();
        int lat; logic hit;
        sk.dir = 2'd0;
        send_note(2'd1, lat, hit);
        checks++; if (lat !== 9) begin errors++; $display("FAIL miss_latency got=%0d want=9", lat); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_result got=%b want=0", hit); end
        checks++; if (sk.miss !== 4'd1) begin errors++; $display("FAIL miss_count got=%0d want=1", sk.miss); end
        checks++; if (sk.combo !== 4'd0) begin errors++; $display("FAIL miss_combo got=%0d want=0", sk.combo); end
        checks++; if (sk.judge_hit !== 1'b0) begin errors++; $display("FAIL miss_hit_hold got=%b want=0", sk.judge_hit); end
    endtask

    task automatic test_full_round();
        int lat; logic hit; int hits; int judged; int p0;
        logic [1:0] lane;
        hits = 0; judged = 0;
        new_round();
        checks++; if (sk.score !== 4'd0 || sk.miss !== 4'd0) begin errors++; $display("FAIL round_clear got=%0d/%0d want=0/0", sk.score, sk.miss); end
        for (int i = 0; i < 10; i++) begin
            lane = 2'(i);
            sk.dir = (i < 7) ? lane : ~lane;
            send_note(lane, lat, hit);
            if (lat > 0) judged++;
            if (hit === 1'b1) hits++;
            if (i == 6) begin
                checks++; if (sk.combo !== 4'd7) begin errors++; $display("FAIL round_combo7 got=%0d want=7", sk.combo); end
            end
        end
        checks++; if (judged !== 10 || hits !== 7) begin errors++; $display("FAIL round_judges got=%0d/%0d want=10/7", judged, hits); end
        checks++; if (sk.score !== 4'd7) begin errors++; $display("FAIL round_score got=%0d want=7", sk.score); end
        checks++; if (sk.miss !== 4'd3) begin errors++; $display("FAIL round_miss got=%0d want=3", sk.miss); end
        checks++; if (sk.combo !== 4'd0) begin errors++; $display("FAIL round_combo got=%0d want=0", sk.combo); end
        p0 = pulse_cnt;
        sk.dir = 2'd0; sk.note_lane = 2'd0; sk.note_arrive = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        sk.note_arrive = 1'b0;
        tick();
        checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL done_pulse got=%0d want=%0d", pulse_cnt, p0); end
        checks++; if (sk.score !== 4'd7 || sk.miss !== 4'd3) begin errors++; $display("FAIL done_hold got=%0d/%0d want=7/3", sk.score, sk.miss); end
    endtask

    task automatic test_abort();
        int lat; logic hit; int p0;
        new_round();
        sk.dir = 2'd3;
        send_note(2'd3, lat, hit);
        p0 = pulse_cnt;
        sk.dir = 2'd1; sk.note_lane = 2'd0; sk.note_arrive = 1'b1;
        tick(); tick(); tick();
        sk.note_arrive = 1'b0; tick();
        sk.note_arrive = 1'b1; tick();
        sk.state = 3'b001;
        tick(); tick(); tick();
        sk.note_arrive = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL abort_pulse got=%0d want=%0d", pulse_cnt, p0); end
        checks++; if (sk.score !== 4'd1 || sk.miss !== 4'd0 || sk.combo !== 4'd1) begin
            errors++; $display("FAIL abort_hold got=%0d/%0d/%0d want=1/0/1", sk.score, sk.miss, sk.combo);
        end
        sk.state = 3'b010;
        tick(); tick();
        checks++; if (sk.score !== 4'd0 || sk.miss !== 4'd0 || sk.combo !== 4'd0) begin
            errors++; $display("FAIL abort_clear got=%0d/%0d/%0d want=0/0/0", sk.score, sk.miss, sk.combo);
        end
    endtask

    task automatic test_reset_mid_judge();
        int lat; logic hit; int p0;
        new_round();
        for (int i = 0; i < 4; i++) begin
            sk.dir = 2'(i);
            send_note(2'(i), lat, hit);
        end
        checks++; if (sk.score !== 4'd4) begin errors++; $display("FAIL rstj_pre_score got=%0d want=4", sk.score); end
        p0 = pulse_cnt;
        sk.dir = 2'd3; sk.note_lane = 2'd0; sk.note_arrive = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (sk.score !== 4'd0 || sk.combo !== 4'd0 || sk.judge_valid !== 1'b0 || sk.judge_hit !== 1'b0) begin
            errors++; $display("FAIL rstj_async got=%0d/%0d/%b/%b want=0/0/0/0", sk.score, sk.combo, sk.judge_valid, sk.judge_hit);
        end
        tick(); tick();
        rst = 1'b1;
        sk.dir = 2'd0;
        for (int i = 0; i < 12; i++) tick();
        checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL rstj_no_event got=%0d want=%0d", pulse_cnt, p0); end
        checks++; if (sk.score !== 4'd0) begin errors++; $display("FAIL rstj_score got=%0d want=0", sk.score); end
        sk.note_arrive = 1'b0;
        tick();
        send_note(2'd0, lat, hit);
        checks++; if (lat !== 2 || sk.score !== 4'd1) begin errors++; $display("FAIL rstj_recover got=lat%0d/score%0d want=lat2/score1", lat, sk.score); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_full_round();
        test_abort();
        test_reset_mid_judge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WINDOW, default 25_000_000, judge window length in clk cycles (0.25 s at 100 MHz); legal range 2..2^26-1.
REQ-002 Parameter ROUND_LEN, default 10, notes per round; legal range 1..15.
REQ-003 clk  input  1  system clock; single clock domain, all state on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion, independent of clk.
REQ-005 state  input  3  game state from controller; 3'b010 = playing, any other value = not playing.
REQ-006 note_arrive  input  1  level from play screen, high while a note occupies the catch row; may stay high many cycles.
REQ-007 note_lane  input  2  lane of the note in the catch row; valid while note_arrive is high.
REQ-008 dir  input  2  current player lane from the Bluetooth control block.
REQ-009 score  output  4  hit count for the current round.
REQ-010 miss  output  4  miss count for the current round.
REQ-011 combo  output  4  current consecutive-hit streak.
REQ-012 judge_valid  output  1  one-cycle pulse when a note is judged.
REQ-013 judge_hit  output  1  judge result, valid with judge_valid; holds its value until the next judge.

Function
REQ-014 FSM states: IDLE, WAIT_NOTE, JUDGE, RESULT, DONE.
REQ-015 IDLE: stay while state != 3'b010; on state == 3'b010, clear score, miss and combo, then go to WAIT_NOTE next cycle.
REQ-016 Edge detect: note_arrive is registered once; a note event = note_arrive high now and low in the previous cycle.
REQ-017 WAIT_NOTE: on a note event, latch note_lane, clear the window counter, go to JUDGE.
REQ-018 JUDGE: each cycle, if dir == latched lane, set the hit flag (sticky); the counter increments each cycle.
REQ-019 JUDGE exit: when counter == WINDOW-1, or when the hit flag is set, go to RESULT; a hit ends the window early.
REQ-020 JUDGE: note events and a falling note_arrive are ignored; the window always runs to its own exit condition.
REQ-021 RESULT, hit: score+1, combo+1 saturating at 15, judge_hit=1.
REQ-022 RESULT, miss: miss+1, combo cleared to 0, judge_hit=0.
REQ-023 RESULT: judge_valid is high exactly this one cycle; counter updates become visible on the following cycle.
REQ-024 After RESULT: if score+miss == ROUND_LEN (evaluated on the updated values), go to DONE; else go to WAIT_NOTE.
REQ-025 DONE: no counting; score, miss and combo hold; go to IDLE when state != 3'b010.
REQ-026 Any state other than IDLE with state != 3'b010: next state IDLE, no count update, no judge_valid, counters hold their values for display.
REQ-027 A judge aborted by REQ-026 is discarded.
REQ-028 score+miss never exceeds ROUND_LEN; score and miss never wrap.
REQ-029 Window counter is wide enough for WINDOW-1 (26 bits at default).
REQ-030 Judge latency: note event at cycle N, dir already matching -> judge_valid at cycle N+2.

Reset
REQ-031 On rst low: FSM = IDLE; score, miss, combo = 0; judge_valid = 0; judge_hit = 0; edge register = 0; window counter = 0.
REQ-032 rst low mid-JUDGE aborts the judge with no count and no pulse.
REQ-033 After rst releases, a note_arrive already high produces no event until it goes low then high again.

Verification (WINDOW=8, ROUND_LEN=10)
REQ-034 state=010, note event lane 2, dir=2 held -> judge_valid 2 cycles after the edge, judge_hit=1, score=1, combo=1.
REQ-035 Note event lane 1, dir=0 throughout -> judge_valid 9 cycles after the edge, judge_hit=0, miss=1, combo=0.
REQ-036 Ten notes, 7 hits then 3 misses -> score=7, miss=3, combo=0, FSM in DONE; an 11th note event -> no judge_valid, counts unchanged.
REQ-037 Second note_arrive edge during JUDGE, then state->001 mid-window -> exactly zero judge_valid pulses, counts held; state->010 again -> all counts cleared.
REQ-038 rst pulsed low mid-JUDGE with score=4 -> all outputs 0 asynchronously, no pulse; note_arrive held high through release -> no event.
